// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray up/down counter slice.
// Helpers work on a fixed 32-bit vector; callers cast to and from their width.
package gray_pkg;

  localparam int GRAY_W_DEF = 4;
  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_vec_t;

  function automatic gray_vec_t bin2gray(input gray_vec_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic onehot_chk(input gray_vec_t v);
    return (v != {GRAY_MAX_W{1'b0}}) &&
           ((v & (v - gray_vec_t'(1))) == {GRAY_MAX_W{1'b0}});
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder.
module gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gry
);

  assign gry = WIDTH'(bin2gray(gray_vec_t'(bin)));

endmodule

// File: rtl/gray_up_dn_counter.sv
// Registered up/down binary counter with synchronous load, aligned Gray output
// and wrap pulse. Optional Gray-adjacency checker enabled by GRAY_CNT_CHECK_EN.
module gray_up_dn_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bn,
  output logic [WIDTH-1:0] gry,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bn_r;
  logic [WIDTH-1:0] gry_r;
  logic             tc_r;
  logic [WIDTH-1:0] bn_next;
  logic [WIDTH-1:0] gry_next;
  logic             step;
  logic             wrap;

  // Next binary value and wrap detect; load wins over counting.
  always_comb begin
    bn_next = bn_r;
    step    = 1'b0;
    wrap    = 1'b0;
    if (load) begin
      bn_next = load_val;
    end else if (en) begin
      step = 1'b1;
      if (up_dn) begin
        bn_next = bn_r + ONE;
        wrap    = (bn_r == ALL_ONES);
      end else begin
        bn_next = bn_r - ONE;
        wrap    = (bn_r == ALL_ZERO);
      end
    end else begin
      bn_next = bn_r;
    end
  end

  // Gray is taken from the next binary value so bn and gry update together.
  gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin (bn_next),
    .gry (gry_next)
  );

  // Count, Gray and terminal-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bn_r  <= ALL_ZERO;
      gry_r <= ALL_ZERO;
      tc_r  <= 1'b0;
    end else begin
      bn_r  <= bn_next;
      gry_r <= gry_next;
      tc_r  <= wrap;
    end
  end

`ifdef GRAY_CNT_CHECK_EN
  logic err_r;

  // Sticky flag: a count step must change exactly one Gray bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (step && !onehot_chk(gray_vec_t'(gry_r ^ gry_next))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign bn  = bn_r;
  assign gry = gry_r;
  assign tc  = tc_r;

endmodule
